// File: rtl/axis_block_averager.sv
// rtl/axis_block_averager.sv - streaming block averager over 2^L signed samples
module axis_block_averager #(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int MAX_LOG2_N       = 8
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [3:0]                  log2_n,
  input  logic                        S_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  output logic                        S_AXIS_tready,
  input  logic                        M_AXIS_tready,
  output logic                        M_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic [7:0]                  block_count
);

  localparam int         ACC_W = AXIS_TDATA_WIDTH + MAX_LOG2_N;
  localparam int         CNT_W = MAX_LOG2_N + 1;
  localparam logic [3:0] MAX_L = 4'(MAX_LOG2_N);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  out_state_t state, state_nxt;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] avg;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        last_idx;
  logic [3:0]              l_reg;
  logic [3:0]              l_req;
  logic [3:0]              l_eff;
  logic                    in_hs;
  logic                    out_hs;
  logic                    close;

  // The first sample of a block uses the live request; later samples use the latched length.
  assign l_req    = (log2_n > MAX_L) ? MAX_L : log2_n;
  assign l_eff    = (cnt == '0) ? l_req : l_reg;
  assign last_idx = (CNT_W'(1) << l_eff) - CNT_W'(1);

  assign M_AXIS_tvalid = (state == FULL);
  assign S_AXIS_tready = ~M_AXIS_tvalid | M_AXIS_tready;
  assign in_hs         = S_AXIS_tvalid & S_AXIS_tready;
  assign out_hs        = M_AXIS_tvalid & M_AXIS_tready;
  assign close         = in_hs & (cnt == last_idx);

  // Closing sum includes the sample on the current handshake; shift gives floor division.
  assign sum = acc + {{MAX_LOG2_N{S_AXIS_tdata[AXIS_TDATA_WIDTH-1]}}, S_AXIS_tdata};
  assign avg = sum >>> l_eff;

  assign block_count = 8'(cnt);

  // Output register occupancy state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // A closing block refills the output even while the old value drains.
  always_comb begin
    state_nxt = state;
    if (close) begin
      state_nxt = FULL;
    end else if (out_hs) begin
      state_nxt = EMPTY;
    end
  end

  // Accumulator, sample counter, latched length and output data.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc          <= '0;
      cnt          <= '0;
      l_reg        <= '0;
      M_AXIS_tdata <= '0;
    end else if (in_hs) begin
      if (cnt == '0) begin
        l_reg <= l_req;
      end
      if (close) begin
        acc          <= '0;
        cnt          <= '0;
        M_AXIS_tdata <= avg[AXIS_TDATA_WIDTH-1:0];
      end else begin
        acc <= sum;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/axis_block_averager.md
AXIS_BLOCK_AVERAGER -- requirements
Module: axis_block_averager

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 16, meaning sample width (signed two's complement, input and output).
REQ-002 SHALL have parameter MAX_LOG2_N, default 8, meaning the largest supported log2 of the block length.
REQ-003 SHALL have port aclk, input, 1, meaning the single clock; all logic is on the rising edge.
REQ-004 SHALL have port aresetn, input, 1, meaning reset; asynchronous assertion, active-low.
REQ-005 SHALL have port log2_n, input, 4, meaning requested block length N = 2^log2_n.
REQ-006 SHALL have port S_AXIS_tvalid, input, 1, meaning an upstream sample (differentiator velocity output) is present.
REQ-007 SHALL have port S_AXIS_tdata, input, AXIS_TDATA_WIDTH, meaning the signed input sample.
REQ-008 SHALL have port S_AXIS_tready, output, 1, meaning the block accepts a sample this cycle.
REQ-009 SHALL have port M_AXIS_tready, input, 1, meaning downstream accepts the output.
REQ-010 SHALL have port M_AXIS_tvalid, output, 1, meaning the output register holds an unconsumed average.
REQ-011 SHALL have port M_AXIS_tdata, output, AXIS_TDATA_WIDTH, meaning the signed block average.
REQ-012 SHALL have port block_count, output, 8, meaning the number of samples accumulated in the current block.

Function
REQ-013 SHALL accept a sample (input handshake) only on cycles where S_AXIS_tvalid and S_AXIS_tready are both 1.
REQ-014 SHALL drive S_AXIS_tready = ~M_AXIS_tvalid | M_AXIS_tready (combinational), so that a held output stalls input and a draining output permits same-cycle acceptance.
REQ-015 SHALL keep an accumulator of AXIS_TDATA_WIDTH+MAX_LOG2_N bits, sign-extending every sample; no overflow is possible by construction.
REQ-016 SHALL latch the effective block length L = min(log2_n, MAX_LOG2_N) on the handshake where block_count is 0; changes to log2_n mid-block SHALL NOT affect the block in progress.
REQ-017 On a handshake with block_count < 2^L-1, SHALL add the sample to the accumulator and increment block_count.
REQ-018 On a handshake with block_count = 2^L-1, SHALL load M_AXIS_tdata with (accumulator + sample) arithmetically right-shifted by L and truncated to AXIS_TDATA_WIDTH, set M_AXIS_tvalid, clear the accumulator, and clear block_count, all on the same edge.
REQ-019 Latency SHALL be one cycle: M_AXIS_tvalid rises on the edge following the closing handshake.
REQ-020 With L = 0, the block SHALL act as a one-deep register slice: each sample appears at the output one cycle later.
REQ-021 M_AXIS_tvalid SHALL clear on an output handshake unless a new block closes on the same edge, in which case it stays 1 with new data (no bubble, no loss).
REQ-022 M_AXIS_tdata and M_AXIS_tvalid SHALL stay stable while M_AXIS_tvalid=1 and M_AXIS_tready=0.
REQ-023 Rounding SHALL be floor (arithmetic shift); for example, the average of -1 and 0 is -1.
REQ-024 Output-register states SHALL be EMPTY (tvalid=0) and FULL (tvalid=1), with these transitions: EMPTY->FULL on block close; FULL->EMPTY on output handshake without block close; FULL->FULL on output handshake with block close; otherwise hold.

Reset
REQ-025 While aresetn=0, the block SHALL asynchronously force M_AXIS_tvalid=0, M_AXIS_tdata=0, block_count=0, accumulator=0, L=0; S_AXIS_tready then reads 1.
REQ-026 A reset asserted mid-block SHALL discard the partial block; the first handshake after release starts a new block using the current log2_n.
REQ-027 Reset deassertion SHALL take effect on the next rising aclk edge.

Verification
REQ-028 With log2_n=2, M_tready=1, and inputs 4,8,12,16 on consecutive cycles, the bench SHALL see a single output of 10, one cycle after the 16 is accepted, and block_count sequencing 0,1,2,3,0.
REQ-029 With log2_n=1 and inputs -1,0, the bench SHALL see an output of -1; with log2_n=3 and eight samples of -32768, it SHALL see -32768 (no overflow).
REQ-030 With log2_n=0 and M_tready held 0 after the first output, the bench SHALL see S_tready=0 while the first value stays held; when M_tready is released, it SHALL see the second sample accepted on that same cycle and the values emitted in order without loss.
REQ-031 When log2_n changes from 2 to 1 after two samples of a block, the bench SHALL see that block still close after four samples, and the next block close after two.
REQ-032 When aresetn is pulsed low asynchronously after three of four samples, the bench SHALL see M_tvalid=0 and block_count=0 immediately, and the next output equal to the mean of four fresh samples only.
REQ-033 With log2_n=15, the bench SHALL see L clamp to MAX_LOG2_N=8, so that 256 samples of 100 produce an output of 100.
